// File: rtl/hold_pulse_mon_pkg.sv
// Shared types for the hold_2 strobe monitor.
// Optional build macro: HOLD_PULSE_MON_TIMESTAMP_EN.
package hold_pulse_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD_G,
      HOLD_F
   } state_t;

   localparam logic SIG_G = 1'b0;
   localparam logic SIG_F = 1'b1;

   localparam int REC_TS_W = 16;
   localparam int REC_LEN_W = 32;

   typedef struct packed {
      logic                 sig;
      logic [REC_LEN_W-1:0] len;
      logic                 short;
   } rec_t;

endpackage

// File: rtl/hold_pulse_mon_if.sv
// One-deep hold record channel with valid/ready handshake.
// rec_ts exists only with HOLD_PULSE_MON_TIMESTAMP_EN.
interface hold_pulse_mon_if
   import hold_pulse_mon_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic             rec_valid;
   logic             rec_ready;
   logic             rec_sig;
   logic [CNT_W-1:0] rec_len;
   logic             rec_short;
`ifdef HOLD_PULSE_MON_TIMESTAMP_EN
   logic [REC_TS_W-1:0] rec_ts;

   modport master (
      output rec_valid, rec_sig, rec_len, rec_short, rec_ts,
      input  rec_ready
   );
   modport slave (
      input  rec_valid, rec_sig, rec_len, rec_short, rec_ts,
      output rec_ready
   );
`else
   modport master (
      output rec_valid, rec_sig, rec_len, rec_short,
      input  rec_ready
   );
   modport slave (
      input  rec_valid, rec_sig, rec_len, rec_short,
      output rec_ready
   );
`endif
endinterface

// File: rtl/hold_pulse_mon_satcnt.sv
// Saturating length counter: load-to-1 or increment, sticks at all-ones.
module hold_pulse_mon_satcnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         sat
);
   assign sat = &q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= W'(1);
      end else if (inc && !sat) begin
         q <= q + W'(1);
      end
   end
endmodule

// File: rtl/hold_pulse_mon.sv
// Hold-length monitor for hold_2 g/f strobes with one-deep record output.
// Optional build macro: HOLD_PULSE_MON_TIMESTAMP_EN (adds rec_ts).
module hold_pulse_mon
   import hold_pulse_mon_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int MAX_HOLD = 16,
   parameter int MIN_HOLD = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             g_i,
   input  logic             f_i,
   input  logic             clr_i,
   hold_pulse_mon_if.master rec,
   output logic [CNT_W-1:0] g_count,
   output logic [CNT_W-1:0] f_count,
   output logic             err_both,
   output logic             err_long,
   output logic             rec_ovf
);
   state_t           state;
   logic [CNT_W-1:0] len;
   logic             len_sat;
   logic             in_g, in_f;
   logic             fall, load, inc, long_hit;
   logic             valid_q, sig_q, short_q;
   logic [CNT_W-1:0] len_q;

   assign in_g = (state == HOLD_G);
   assign in_f = (state == HOLD_F);
   assign fall = (in_g && !g_i) || (in_f && !f_i);
   assign inc  = (in_g && g_i) || (in_f && f_i);
   assign load = ((state == IDLE) && (g_i ^ f_i))
               || (in_g && !g_i && f_i)
               || (in_f && !f_i && g_i);

   // Saturated length never "becomes" MAX_HOLD again, so one set per hold.
   assign long_hit = (inc && !len_sat && (int'(len) + 1 == MAX_HOLD))
                   || (load && (MAX_HOLD == 1));

   hold_pulse_mon_satcnt #(.W(CNT_W)) u_len (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .inc  (inc),
      .q    (len),
      .sat  (len_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         g_count  <= '0;
         f_count  <= '0;
         err_both <= 1'b0;
         err_long <= 1'b0;
         rec_ovf  <= 1'b0;
         valid_q  <= 1'b0;
         sig_q    <= 1'b0;
         len_q    <= '0;
         short_q  <= 1'b0;
      end else begin
         if (clr_i) begin
            err_both <= 1'b0;
            err_long <= 1'b0;
            rec_ovf  <= 1'b0;
         end
         if (g_i && f_i) err_both <= 1'b1;
         if (long_hit) err_long <= 1'b1;

         if (fall) begin
            valid_q <= 1'b1;
            sig_q   <= in_f ? SIG_F : SIG_G;
            len_q   <= len;
            short_q <= (int'(len) < MIN_HOLD);
            if (valid_q && !rec.rec_ready) rec_ovf <= 1'b1;
         end else if (valid_q && rec.rec_ready) begin
            valid_q <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (g_i && !f_i) state <= HOLD_G;
               else if (f_i && !g_i) state <= HOLD_F;
            end
            HOLD_G: begin
               if (!g_i) begin
                  g_count <= g_count + CNT_W'(1);
                  state   <= f_i ? HOLD_F : IDLE;
               end
            end
            HOLD_F: begin
               if (!f_i) begin
                  f_count <= f_count + CNT_W'(1);
                  state   <= g_i ? HOLD_G : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rec.rec_valid = valid_q;
   assign rec.rec_sig   = sig_q;
   assign rec.rec_len   = len_q;
   assign rec.rec_short = short_q;

`ifdef HOLD_PULSE_MON_TIMESTAMP_EN
   logic [REC_TS_W-1:0] ts, ts_start, ts_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts       <= '0;
         ts_start <= '0;
         ts_q     <= '0;
      end else begin
         ts <= ts + REC_TS_W'(1);
         if (load) ts_start <= ts;
         if (fall) ts_q <= ts_start;
      end
   end

   assign rec.rec_ts = ts_q;
`endif
endmodule

// File: tb/tb_hold_pulse_mon.sv
// Scoreboard bench for hold_pulse_mon: random + directed strobe traffic.
// A run-length protocol model predicts records, counters and sticky flags.
`timescale 1ns/1ps
module tb_hold_pulse_mon;
   import hold_pulse_mon_pkg::*;

   localparam int W    = 8;
   localparam int MAXH = 16;
   localparam int MINH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, g_i, f_i, clr_i;
   logic [W-1:0] g_count, f_count;
   logic         err_both, err_long, rec_ovf;

   hold_pulse_mon_if #(.CNT_W(W)) rec ();

   hold_pulse_mon #(.CNT_W(W), .MAX_HOLD(MAXH), .MIN_HOLD(MINH)) dut (
      .clk      (clk),
      .rst      (rst),
      .g_i      (g_i),
      .f_i      (f_i),
      .clr_i    (clr_i),
      .rec      (rec),
      .g_count  (g_count),
      .f_count  (f_count),
      .err_both (err_both),
      .err_long (err_long),
      .rec_ovf  (rec_ovf)
   );

   // Narrow instance for the saturation boundary.
   logic       rst4, g4, f4, clr4;
   logic [3:0] g_count4, f_count4;
   logic       err_both4, err_long4, rec_ovf4;

   hold_pulse_mon_if #(.CNT_W(4)) rec4 ();

   hold_pulse_mon #(.CNT_W(4), .MAX_HOLD(MAXH), .MIN_HOLD(MINH)) dut4 (
      .clk      (clk),
      .rst      (rst4),
      .g_i      (g4),
      .f_i      (f4),
      .clr_i    (clr4),
      .rec      (rec4),
      .g_count  (g_count4),
      .f_count  (f_count4),
      .err_both (err_both4),
      .err_long (err_long4),
      .rec_ovf  (rec_ovf4)
   );

   int   vectors = 0;
   int   errors  = 0;
   bit   done    = 1'b0;
   rec_t exp_q[$];

   // Model: which strobe is being held (0 none, 1 g, 2 f) and its raw run.
   int m_cur, m_run, m_gc, m_fc;
   bit m_eb, m_el, m_ovf, m_pend;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   function automatic int satw(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_edge();
      rec_t r;
      bit   newr, eb, el, held, other;
      int   l;
      r = '0;
      if (rst) begin
         m_cur = 0; m_run = 0; m_gc = 0; m_fc = 0;
         m_eb = 0; m_el = 0; m_ovf = 0; m_pend = 0;
         exp_q.delete();
         return;
      end
      newr = 0;
      el   = 0;
      eb   = g_i && f_i;
      if (m_cur != 0) begin
         held  = (m_cur == 1) ? g_i : f_i;
         other = (m_cur == 1) ? f_i : g_i;
         if (held) begin
            m_run++;
            el = (m_run == MAXH) && (MAXH <= (1 << W) - 1);
         end else begin
            l       = satw(m_run, W);
            r.sig   = (m_cur == 2);
            r.len   = l;
            r.short = (l < MINH);
            newr    = 1;
            if (m_cur == 1) m_gc = (m_gc + 1) % (1 << W);
            else m_fc = (m_fc + 1) % (1 << W);
            m_cur = other ? 3 - m_cur : 0;
            m_run = other ? 1 : 0;
         end
      end else if (g_i != f_i) begin
         m_cur = g_i ? 1 : 2;
         m_run = 1;
      end
      if (clr_i) begin
         m_eb = 0; m_el = 0; m_ovf = 0;
      end
      if (eb) m_eb = 1;
      if (el) m_el = 1;
      if (newr) begin
         if (m_pend && !rec.rec_ready) begin
            m_ovf = 1;
            void'(exp_q.pop_back());
         end
         exp_q.push_back(r);
         m_pend = 1;
      end else if (m_pend && rec.rec_ready) begin
         m_pend = 0;
      end
   endtask

   task automatic step(input bit g, input bit f, input bit rdy,
                       input bit c, input bit r);
      g_i = g; f_i = f; rec.rec_ready = rdy; clr_i = c; rst = r;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   // Monitor: compares live state every cycle, pops a record on transfer.
   always @(negedge clk) begin
      rec_t e;
      if (!done) begin
         chk("rec_valid", rec.rec_valid, m_pend);
         chk("g_count", g_count, m_gc);
         chk("f_count", f_count, m_fc);
         chk("err_both", err_both, m_eb);
         chk("err_long", err_long, m_el);
         chk("rec_ovf", rec_ovf, m_ovf);
         if (rec.rec_valid === 1'b1 && rec.rec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_record: got len %0d expected none",
                        rec.rec_len);
            end else begin
               e = exp_q.pop_front();
               chk("rec_sig", rec.rec_sig, e.sig);
               chk("rec_len", rec.rec_len, e.len);
               chk("rec_short", rec.rec_short, e.short);
            end
         end
      end
   end

   task automatic main_seq();
      bit g, f;
      int p;
      repeat (2) step(0, 0, 1, 0, 1);
      // single g hold of 5, held unaccepted for one cycle
      repeat (5) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      repeat (2) step(0, 0, 1, 0, 0);
      // g 3 then f 1 with no acceptance: overwrite
      repeat (3) step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      repeat (2) step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      // long hold crosses MAX_HOLD
      repeat (20) step(1, 0, 1, 0, 0);
      repeat (2) step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      // both high from IDLE, then clear
      step(1, 1, 1, 0, 0);
      repeat (2) step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      // back-to-back g 4 -> f 3 handoff
      repeat (4) step(1, 0, 1, 0, 0);
      repeat (3) step(0, 1, 1, 0, 0);
      repeat (2) step(0, 0, 1, 0, 0);
      // reset mid-hold, strobe still high afterwards
      repeat (3) step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 1);
      repeat (3) step(1, 0, 1, 0, 0);
      repeat (2) step(0, 0, 1, 0, 0);
      // random traffic, alternating short and long hold phases
      g = 0;
      f = 0;
      for (int i = 0; i < 3000; i++) begin
         p = ((i / 500) % 2 == 1) ? 15 : 3;
         if ($urandom_range(0, p) == 0) g = !g;
         if ($urandom_range(0, p) == 0) f = !f;
         step(g, f, $urandom_range(0, 9) < 7,
              $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
      end
      repeat (4) step(0, 0, 1, 0, 0);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic small_test();
      bit found;
      rst4 = 1; g4 = 0; f4 = 0; clr4 = 0; rec4.rec_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      rst4 = 0;
      g4   = 1;
      repeat (20) @(posedge clk);
      #1;
      g4 = 0;
      found = 0;
      for (int i = 0; i < 5 && !found; i++) begin
         @(negedge clk);
         if (rec4.rec_valid === 1'b1) found = 1;
      end
      if (!found) begin
         vectors++;
         errors++;
         $display("FAIL sat_timeout: got no record expected one");
      end else begin
         chk("sat_len", rec4.rec_len, 15);
         chk("sat_sig", rec4.rec_sig, 0);
         chk("sat_short", rec4.rec_short, 0);
         chk("sat_err_long", err_long4, 0);
         chk("sat_g_count", g_count4, 1);
      end
      rec4.rec_ready = 1;
   endtask

   initial begin
      fork
         main_seq();
         small_test();
      join
      @(negedge clk);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/hold_pulse_mon.md
Name: hold_pulse_mon

Overview:
- Downstream consumer of the hold_2 FSM outputs g and f; samples both strobes every clock.
- Measures each high-hold length, counts completed holds per signal and flags protocol violations.
- Each completed hold is presented as a one-deep record on a valid/ready interface for a logger or scoreboard stage.

Parameters:
CNT_W, 8, width of hold-length field and per-signal hold counters
MAX_HOLD, 16, hold length (cycles) at which err_long asserts
MIN_HOLD, 2, records with len < MIN_HOLD carry rec_short=1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
g_i  input  1  g strobe from hold_2
f_i  input  1  f strobe from hold_2
clr_i  input  1  synchronous clear of sticky error flags
rec_valid  output  1  record pending
rec_ready  input  1  consumer accepts record
rec_sig  output  1  0 = g hold, 1 = f hold
rec_len  output  CNT_W  hold length in cycles, saturating
rec_short  output  1  rec_len < MIN_HOLD
g_count  output  CNT_W  completed g holds, wraps mod 2^CNT_W
f_count  output  CNT_W  completed f holds, wraps mod 2^CNT_W
err_both  output  1  sticky: g_i and f_i sampled high together
err_long  output  1  sticky: a hold reached MAX_HOLD cycles
rec_ovf  output  1  sticky: unaccepted record overwritten

Behaviour:
- Reset: every output is 0, state IDLE, len 0. Reset mid-hold discards the hold; no record is emitted.
  - If g_i is high at the first post-reset edge, that edge starts a new hold with len=1.
- Sampling: g_i/f_i are synchronous to clk; no synchronizer.
- FSM states: IDLE, HOLD_G, HOLD_F.
  - IDLE: g_i&!f_i -> HOLD_G, len=1. f_i&!g_i -> HOLD_F, len=1. Both high -> set err_both, stay IDLE.
  - HOLD_G: g_i high -> len+1, saturating at 2^CNT_W-1. If f_i is also high, set err_both; the hold continues.
  - HOLD_G, g_i low -> emit record {0, len}, g_count+1, then:
    - f_i high -> HOLD_F, len=1 (back-to-back handoff, no IDLE cycle);
    - else -> IDLE.
  - HOLD_F: symmetric, with f_count.
- err_long: set at the edge where len becomes MAX_HOLD while still held; a hold sets it at most once.
- Record timing: loaded at the edge that samples the strobe low; rec_valid is high from the following cycle, i.e. 1 cycle after the falling strobe.
- Handshake: record fields are stable while rec_valid && !rec_ready. Transfer occurs on rec_valid && rec_ready; rec_valid drops next cycle unless a new record loads at that edge.
- Simultaneous new record and pending unaccepted record: new record overwrites and rec_ovf sets.
- Simultaneous new record and acceptance: new record loads, no overflow.
- rec_short = (len < MIN_HOLD), registered with the record.
- Errors: err_both, err_long and rec_ovf clear only on rst or clr_i.
  - If clr_i coincides with a new error event, the set wins.
- Counters: g_count and f_count wrap 2^CNT_W-1 -> 0 with no flag.

Optional Feature:
- Macro HOLD_PULSE_MON_TIMESTAMP_EN.
- Defined: adds a 16-bit free-running cycle counter (reset 0, wraps) and output port rec_ts[15:0].
  - rec_ts = counter value at the edge the hold started; captured with the record.
- Undefined: no counter and no rec_ts port; all other behaviour is identical.

Decomposition:
- Package hold_pulse_mon_pkg:
  - state enum {IDLE, HOLD_G, HOLD_F};
  - constants SIG_G=1'b0, SIG_F=1'b1;
  - record struct {sig, len, short}.
- Sub-module hold_pulse_mon_satcnt: parameterised saturating counter with load-1 and increment; used for len.

Test Plan:
- rst high 2 cycles, then g_i high 5 cycles, low -> one cycle after the fall rec_valid=1, rec_sig=0, rec_len=5, rec_short=0, g_count=1.
- rec_ready held 0, g hold of 3 then f hold of 1 -> f record overwrites: rec_sig=1, rec_len=1, rec_short=1, rec_ovf=1; f_count=1.
- g_i high 20 cycles -> err_long sets on the 16th held cycle; record rec_len=20. Repeat with CNT_W=4: rec_len saturates at 15.
- g_i and f_i high together for 1 cycle from IDLE -> err_both=1, no record, counts unchanged. Pulse clr_i -> err_both=0.
- g_i high 4 cycles then falls exactly as f_i rises for 3 cycles -> g record len=4, then f record len=3, no IDLE gap, no err_both. With rec_ready=1 both records are accepted, rec_ovf=0.
- Assert rst during a g hold of 6 (at cycle 3) -> all outputs 0, no record; g_i still high afterwards -> new hold counted from len=1.
